// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch/loader front end.
//   fetch_state_t : controller states (RUN fetches, LOAD assembles bytes,
//                   DRAIN lets the final write land before fetch resumes)
//   inst_bytes()  : bytes per instruction word
`timescale 1ns/1ps
package fetch_pkg;
  typedef enum logic [1:0] {RUN, LOAD, DRAIN} fetch_state_t;

  function automatic int inst_bytes(input int width);
    return width / 8;
  endfunction
endpackage

// File: rtl/inst_mem_sdp.sv
// Simple dual-port instruction RAM: one write port, one registered read port.
//   CLK, reset : clock; sync active-high reset clears only the read register
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i, rdata_o : read port, data valid the cycle after re_i
`timescale 1ns/1ps
module inst_mem_sdp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  // Array kept out of the reset path so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge CLK) begin
    if (reset)     rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/inst_fetch_loader.sv
// Fetch stage with integrated byte-stream program loader.
//   CLK, reset            : clock, sync active-high reset
//   pc, pc1, stall        : fetch address, pc+1 tag, hold fetch outputs
//   input_data/_start/_end/_valid : host byte stream and framing pulses
//   inst, inst_enable     : fetched word and its valid flag
//   pc_next, pc1_next     : tags aligned with inst
//   load_busy, load_words, load_error : loader status
`timescale 1ns/1ps
module inst_fetch_loader import fetch_pkg::*; #(
  parameter int INST_MEM_WIDTH = 10,
  parameter int INST_WIDTH     = 32,
  parameter bit BIG_ENDIAN     = 1'b1
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic                      stall,
  input  logic [7:0]                input_data,
  input  logic                      input_start,
  input  logic                      input_end,
  input  logic                      input_valid,
  output logic [INST_WIDTH-1:0]     inst,
  output logic                      inst_enable,
  output logic [INST_MEM_WIDTH-1:0] pc_next,
  output logic [INST_MEM_WIDTH-1:0] pc1_next,
  output logic                      load_busy,
  output logic [INST_MEM_WIDTH:0]   load_words,
  output logic                      load_error
);
  localparam int NB = inst_bytes(INST_WIDTH);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = INST_MEM_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH     = {1'b1, {INST_MEM_WIDTH{1'b0}}};
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

  fetch_state_t              state_q, state_d;
  logic [CW-1:0]             byte_cnt_q, byte_cnt_d;
  logic [INST_WIDTH-1:0]     asm_q, asm_d;
  logic                      wr_pend_q, wr_pend_d;
  logic [INST_WIDTH-1:0]     wr_word_q, wr_word_d;
  logic [INST_MEM_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [LW-1:0]             load_words_q, load_words_d;
  logic                      load_error_q, load_error_d;
  logic                      inst_enable_q, inst_enable_d;
  logic [INST_MEM_WIDTH-1:0] pc_next_q, pc_next_d, pc1_next_q, pc1_next_d;

  logic [INST_WIDTH-1:0] asm_shift, asm_after, pad_word;
  logic [CW-1:0]         cnt_after;
  logic                  accept, word_done, end_now, partial, mem_full, mem_we;
  int                    pad_bits;

  // Byte assembler datapath. Stale bytes of the previous word are shifted
  // out by the zero-padding shift, so the register need not be cleared per word.
  always_comb begin
    accept  = (state_q == LOAD) && input_valid && !input_start;
    end_now = (state_q == LOAD) && input_end && !input_start;
    if (BIG_ENDIAN) asm_shift = (asm_q << 8) | INST_WIDTH'(input_data);
    else            asm_shift = (asm_q >> 8) | (INST_WIDTH'(input_data) << (INST_WIDTH - 8));
    word_done = accept && (byte_cnt_q == LAST_BYTE);
    asm_after = accept ? asm_shift : asm_q;
    cnt_after = accept ? (word_done ? '0 : byte_cnt_q + 1'b1) : byte_cnt_q;
    partial   = end_now && (cnt_after != '0);
    pad_bits  = (NB - int'(cnt_after)) * 8;
    pad_word  = BIG_ENDIAN ? (asm_after << pad_bits) : (asm_after >> pad_bits);
  end

  assign mem_full = (load_words_q == DEPTH);
  // A write pending from an aborted or restarted load never lands.
  assign mem_we   = wr_pend_q && !mem_full && !input_start && !reset;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    wr_pend_d    = 1'b0;
    wr_word_d    = wr_word_q;
    wr_addr_d    = wr_addr_q;
    load_words_d = load_words_q;
    load_error_d = load_error_q;

    // Commit the word assembled last cycle, or drop it once memory is full.
    if (wr_pend_q) begin
      if (mem_full) begin
        load_error_d = 1'b1;
      end else begin
        wr_addr_d    = wr_addr_q + 1'b1;
        load_words_d = load_words_q + 1'b1;
      end
    end

    case (state_q)
      LOAD: begin
        asm_d      = asm_after;
        byte_cnt_d = cnt_after;
        if (word_done) begin
          wr_pend_d = 1'b1;
          wr_word_d = asm_shift;
        end
        if (end_now) begin
          state_d = DRAIN;
          if (partial) begin
            wr_pend_d    = 1'b1;
            wr_word_d    = pad_word;
            load_error_d = 1'b1;
            byte_cnt_d   = '0;
          end
        end
      end
      DRAIN:   state_d = RUN;
      default: state_d = state_q;
    endcase

    if (input_start) begin
      state_d      = LOAD;
      byte_cnt_d   = '0;
      asm_d        = '0;
      wr_pend_d    = 1'b0;
      wr_addr_d    = '0;
      load_words_d = '0;
      load_error_d = 1'b0;
    end

    pc_next_d  = stall ? pc_next_q  : pc;
    pc1_next_d = stall ? pc1_next_q : pc1;
    // Valid only once a read has been issued from RUN, i.e. after the
    // final loader write is guaranteed visible.
    if (state_d != RUN)                  inst_enable_d = 1'b0;
    else if (state_q == RUN && !stall)   inst_enable_d = 1'b1;
    else                                 inst_enable_d = inst_enable_q;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= RUN;
      byte_cnt_q    <= '0;
      asm_q         <= '0;
      wr_pend_q     <= 1'b0;
      wr_word_q     <= '0;
      wr_addr_q     <= '0;
      load_words_q  <= '0;
      load_error_q  <= 1'b0;
      inst_enable_q <= 1'b1;
      pc_next_q     <= '0;
      pc1_next_q    <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      wr_pend_q     <= wr_pend_d;
      wr_word_q     <= wr_word_d;
      wr_addr_q     <= wr_addr_d;
      load_words_q  <= load_words_d;
      load_error_q  <= load_error_d;
      inst_enable_q <= inst_enable_d;
      pc_next_q     <= pc_next_d;
      pc1_next_q    <= pc1_next_d;
    end
  end

  inst_mem_sdp #(.ADDR_W(INST_MEM_WIDTH), .DATA_W(INST_WIDTH)) u_mem (
    .CLK     (CLK),
    .reset   (reset),
    .we_i    (mem_we),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_word_q),
    .re_i    (!stall),
    .raddr_i (pc),
    .rdata_o (inst)
  );

  assign inst_enable = inst_enable_q;
  assign pc_next     = pc_next_q;
  assign pc1_next    = pc1_next_q;
  assign load_busy   = (state_q != RUN);
  assign load_words  = load_words_q;
  assign load_error  = load_error_q;
endmodule
